// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl
//   Single-port access controller for NB = 2**NBANK_LOG2 asynchronous SRAM
//   banks. A requester holds req until it sees a one-cycle ack. Reads assert
//   ce_n/oe_n on the selected bank and capture sram_dq_i after RD_WAIT wait
//   cycles. Writes run through setup, we_n pulse and hold phases. Address,
//   data and byte lanes stay stable across the whole write.
//   Every SRAM-facing output comes straight from a flop, so the pads see no
//   decode glitches. NBANK_LOG2 must be at least 1.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   req, we             request (held until ack) and direction (1 = write)
//   addr                word address; the top NBANK_LOG2 bits select the bank
//   be, wdata           write byte enables (active-high) and write data
//   rdata, ack, busy    registered read data, completion pulse, not-idle flag
//   sram_addr           per-bank word address, bank k in slice k
//   sram_dq_o/_i        shared write data out / muxed read data in
//   sram_dq_oe          per-bank data-pad output enable
//   sram_ce_n/oe_n/we_n per-bank active-low strobes
//   sram_be_n           per-bank active-low byte lanes
module sram_bank_ctrl #(
  parameter int DATA_W     = 32,
  parameter int BANK_AW    = 20,
  parameter int NBANK_LOG2 = 1,
  parameter int RD_WAIT    = 1,
  parameter int WR_WAIT    = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       req,
  input  logic                                       we,
  input  logic [BANK_AW+NBANK_LOG2-1:0]              addr,
  input  logic [DATA_W/8-1:0]                        be,
  input  logic [DATA_W-1:0]                          wdata,
  output logic [DATA_W-1:0]                          rdata,
  output logic                                       ack,
  output logic                                       busy,
  output logic [(2**NBANK_LOG2)*BANK_AW-1:0]         sram_addr,
  output logic [DATA_W-1:0]                          sram_dq_o,
  input  logic [DATA_W-1:0]                          sram_dq_i,
  output logic [(2**NBANK_LOG2)-1:0]                 sram_dq_oe,
  output logic [(2**NBANK_LOG2)-1:0]                 sram_ce_n,
  output logic [(2**NBANK_LOG2)-1:0]                 sram_oe_n,
  output logic [(2**NBANK_LOG2)-1:0]                 sram_we_n,
  output logic [(2**NBANK_LOG2)*(DATA_W/8)-1:0]      sram_be_n
);

  localparam int NB = 2 ** NBANK_LOG2;
  localparam int BW = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  state_t                state_q, state_d;
  logic [3:0]            waitCnt_q, waitCnt_d;
  logic [NBANK_LOG2-1:0] bank_q, bank_d;
  logic [BW-1:0]         be_q, be_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic [NB*BANK_AW-1:0] sramAddr_q, sramAddr_d;
  logic [DATA_W-1:0]     dqO_q, dqO_d;
  logic [NB-1:0]         dqOe_q, dqOe_d;
  logic [NB-1:0]         ceN_q, ceN_d;
  logic [NB-1:0]         oeN_q, oeN_d;
  logic [NB-1:0]         weN_q, weN_d;
  logic [NB*BW-1:0]      beN_q, beN_d;
  logic [NBANK_LOG2-1:0] reqBank;

  assign reqBank = addr[BANK_AW +: NBANK_LOG2];

  // Next-state and next-output logic. Strobes are computed one edge ahead
  // so they come out of flops. Leaving an access restores every bank to
  // its all-inactive pattern at once. That is safe because only one bank
  // is ever active. The ack_q guard in IDLE stops a req that is still held
  // on the ack cycle from starting a second access.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    bank_d     = bank_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    sramAddr_d = sramAddr_q;
    dqO_d      = dqO_q;
    dqOe_d     = dqOe_q;
    ceN_d      = ceN_q;
    oeN_d      = oeN_q;
    weN_d      = weN_q;
    beN_d      = beN_q;

    case (state_q)
      IDLE: begin
        if (req && !ack_q) begin
          bank_d         = reqBank;
          be_d           = be;
          ceN_d[reqBank] = 1'b0;
          for (int k = 0; k < NB; k++) begin
            if (reqBank == NBANK_LOG2'(k)) begin
              sramAddr_d[k*BANK_AW +: BANK_AW] = addr[BANK_AW-1:0];
              beN_d[k*BW +: BW]                = we ? ~be : '0;
            end
          end
          if (we) begin
            dqO_d           = wdata;
            dqOe_d[reqBank] = 1'b1;
            state_d         = WR_SETUP;
          end else begin
            oeN_d[reqBank] = 1'b0;
            waitCnt_d      = 4'(RD_WAIT);
            state_d        = RD;
          end
        end
      end

      RD: begin
        if (waitCnt_q == 4'd0) begin
          rdata_d = sram_dq_i;
          ack_d   = 1'b1;
          ceN_d   = '1;
          oeN_d   = '1;
          beN_d   = '1;
          state_d = IDLE;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end

      WR_SETUP: begin
        if (be_q != '0) begin
          weN_d[bank_q] = 1'b0;
        end
        waitCnt_d = 4'(WR_WAIT - 1);
        state_d   = WR_PULSE;
      end

      WR_PULSE: begin
        if (waitCnt_q == 4'd0) begin
          weN_d   = '1;
          state_d = WR_HOLD;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end

      WR_HOLD: begin
        ceN_d   = '1;
        dqOe_d  = '0;
        beN_d   = '1;
        weN_d   = '1;
        ack_d   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset drives every strobe inactive
  // immediately, which also cuts a we_n pulse short at the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      bank_q     <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      sramAddr_q <= '0;
      dqO_q      <= '0;
      dqOe_q     <= '0;
      ceN_q      <= '1;
      oeN_q      <= '1;
      weN_q      <= '1;
      beN_q      <= '1;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      bank_q     <= bank_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      sramAddr_q <= sramAddr_d;
      dqO_q      <= dqO_d;
      dqOe_q     <= dqOe_d;
      ceN_q      <= ceN_d;
      oeN_q      <= oeN_d;
      weN_q      <= weN_d;
      beN_q      <= beN_d;
    end
  end

  assign rdata      = rdata_q;
  assign ack        = ack_q;
  assign busy       = (state_q != IDLE);
  assign sram_addr  = sramAddr_q;
  assign sram_dq_o  = dqO_q;
  assign sram_dq_oe = dqOe_q;
  assign sram_ce_n  = ceN_q;
  assign sram_oe_n  = oeN_q;
  assign sram_we_n  = weN_q;
  assign sram_be_n  = beN_q;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb_sram_bank_ctrl
//   Bench for sram_bank_ctrl. Instance dut uses the default parameters and is
//   attached to a byte-lane SRAM model. Instance dutAlt uses RD_WAIT=0 and
//   WR_WAIT=3 and is attached to an address-pattern read source.
module tb_sram_bank_ctrl;

  localparam int DW = 32;
  localparam int AW = 20;
  localparam int NB = 2;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic          req, we;
  logic [AW:0]   addr;
  logic [BW-1:0] be;
  logic [DW-1:0] wdata, rdata, sramDqO, sramDqI;
  logic          ack, busy;
  logic [NB*AW-1:0] sramAddr;
  logic [NB-1:0]    sramDqOe, ceN, oeN, weN;
  logic [NB*BW-1:0] beN;

  logic          req2, we2;
  logic [AW:0]   addr2;
  logic [BW-1:0] be2;
  logic [DW-1:0] wdata2, rdata2, sramDqO2, sramDqI2;
  logic          ack2, busy2;
  logic [NB*AW-1:0] sramAddr2;
  logic [NB-1:0]    sramDqOe2, ceN2, oeN2, weN2;
  logic [NB*BW-1:0] beN2;

  int checks = 0;
  int errors = 0;

  sram_bank_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy),
    .sram_addr(sramAddr), .sram_dq_o(sramDqO), .sram_dq_i(sramDqI),
    .sram_dq_oe(sramDqOe), .sram_ce_n(ceN), .sram_oe_n(oeN),
    .sram_we_n(weN), .sram_be_n(beN)
  );

  sram_bank_ctrl #(.RD_WAIT(0), .WR_WAIT(3)) dutAlt (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .be(be2),
    .wdata(wdata2), .rdata(rdata2), .ack(ack2), .busy(busy2),
    .sram_addr(sramAddr2), .sram_dq_o(sramDqO2), .sram_dq_i(sramDqI2),
    .sram_dq_oe(sramDqOe2), .sram_ce_n(ceN2), .sram_oe_n(oeN2),
    .sram_we_n(weN2), .sram_be_n(beN2)
  );

  // The second instance reads back a word built from the bank address
  // it is driving.
  assign sramDqI2 = !ceN2[1] ? {12'hC0D, sramAddr2[2*AW-1:AW]}
                             : {12'hC0D, sramAddr2[AW-1:0]};

  logic [DW-1:0] sramMem [int];
  logic [DW-1:0] refMem [int];

  function automatic logic [DW-1:0] initWord(input int key);
    return 32'h5A00_0000 ^ key;
  endfunction

  function automatic logic [DW-1:0] refRead(input int key);
    return refMem.exists(key) ? refMem[key] : initWord(key);
  endfunction

  function automatic void refWrite(input int key, input logic [BW-1:0] b,
                                   input logic [DW-1:0] d);
    logic [DW-1:0] w;
    w = refRead(key);
    for (int l = 0; l < BW; l++) begin
      if (b[l]) w[l*8 +: 8] = d[l*8 +: 8];
    end
    refMem[key] = w;
  endfunction

  // Byte-lane SRAM model. At each falling edge it writes any bank whose
  // ce_n and we_n are both low, then presents the word of the bank that
  // has ce_n and oe_n low.
  always @(negedge clk) begin
    logic [DW-1:0] rd;
    logic [DW-1:0] w;
    int key;
    rd = '0;
    for (int k = 0; k < NB; k++) begin
      if (ceN[k] === 1'b0) begin
        key = (k << AW) | int'(sramAddr[k*AW +: AW]);
        if (!sramMem.exists(key)) sramMem[key] = initWord(key);
        if (weN[k] === 1'b0) begin
          w = sramMem[key];
          for (int l = 0; l < BW; l++) begin
            if (beN[k*BW+l] === 1'b0) w[l*8 +: 8] = sramDqO[l*8 +: 8];
          end
          sramMem[key] = w;
        end
        if (oeN[k] === 1'b0) rd = sramMem[key];
      end
    end
    sramDqI = rd;
  end

  function automatic logic busOk(input logic [NB-1:0] ce, oe, wr, dqoe,
                                 input logic [NB*BW-1:0] ben);
    int low;
    logic ok;
    low = 0;
    ok  = 1'b1;
    for (int k = 0; k < NB; k++) begin
      if (ce[k] !== 1'b1) low++;
      if (oe[k] !== 1'b1 && dqoe[k] !== 1'b0) ok = 1'b0;
      if (ce[k] === 1'b1 && (oe[k] !== 1'b1 || wr[k] !== 1'b1 ||
          dqoe[k] !== 1'b0 || ben[k*BW +: BW] !== '1)) ok = 1'b0;
    end
    if (low > 1) ok = 1'b0;
    return ok;
  endfunction

  // Bus-protocol and ack-width watcher for both instances, sampled
  // mid-cycle.
  logic ackPrev = 1'b0;
  logic ack2Prev = 1'b0;
  always @(negedge clk) begin
    checks += 4;
    if (!busOk(ceN, oeN, weN, sramDqOe, beN)) begin
      errors++;
      $display("[TB] FAIL bus protocol dut: ce_n=%b oe_n=%b we_n=%b dq_oe=%b be_n=%b required legal strobes",
               ceN, oeN, weN, sramDqOe, beN);
    end
    if (!busOk(ceN2, oeN2, weN2, sramDqOe2, beN2)) begin
      errors++;
      $display("[TB] FAIL bus protocol dutAlt: ce_n=%b oe_n=%b we_n=%b dq_oe=%b be_n=%b required legal strobes",
               ceN2, oeN2, weN2, sramDqOe2, beN2);
    end
    if (ack === 1'b1 && ackPrev === 1'b1) begin
      errors++;
      $display("[TB] FAIL ack width dut: high 2 cycles, required 1");
    end
    if (ack2 === 1'b1 && ack2Prev === 1'b1) begin
      errors++;
      $display("[TB] FAIL ack width dutAlt: high 2 cycles, required 1");
    end
    ackPrev  = ack;
    ack2Prev = ack2;
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Runs one access on dut. Inputs are scrambled after the accept edge, and
  // the task returns the ack latency in edges after T0, the number of cycles
  // with the bank's we_n low, and whether busy tracked the access.
  task automatic applyStimulus(input logic w, input logic [AW:0] a,
                               input logic [BW-1:0] b, input logic [DW-1:0] d,
                               output int lat, output int weLow,
                               output logic busyOk);
    int n;
    int bank;
    logic [31:0] rnd;
    bank = int'(a[AW]);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    n = 0; weLow = 0; busyOk = 1'b1; lat = -1;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        rnd = $urandom; addr = rnd[AW:0]; be = rnd[31:28];
        wdata = $urandom; we = rnd[27];
      end
      if (weN[bank] === 1'b0) weLow++;
      if (ack === 1'b1) begin
        lat = n - 1;
        if (busy !== 1'b0) busyOk = 1'b0;
        break;
      end
      if (busy !== 1'b1) busyOk = 1'b0;
    end
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulusAlt(input logic w, input logic [AW:0] a,
                                  input logic [BW-1:0] b, input logic [DW-1:0] d,
                                  output int lat, output int weLow);
    int n;
    int bank;
    bank = int'(a[AW]);
    req2 = 1'b1; we2 = w; addr2 = a; be2 = b; wdata2 = d;
    n = 0; weLow = 0; lat = -1;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        addr2 = ~a; wdata2 = ~d; be2 = ~b;
      end
      if (weN2[bank] === 1'b0) weLow++;
      if (ack2 === 1'b1) begin
        lat = n - 1;
        break;
      end
    end
    req2 = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          w;
    logic [AW:0]   a;
    logic [BW-1:0] b;
    logic [DW-1:0] d;
    int            expLat;
    int            expWeLow;
    logic [DW-1:0] expRdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, weLow, starts, acks;
    logic busyOk, gapOk, typeOk, prevAck, prevBusy, ok;
    logic [DW-1:0] lastRead, expRd;
    logic [AW:0] a;
    logic [BW-1:0] b;
    logic [DW-1:0] d;
    logic w;
    int key;

    vecs[0] = '{1'b0, 21'h000010, 4'h0, 32'h0,        2, 0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 21'h100020, 4'hF, 32'h12345678, 3, 1, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 21'h100020, 4'h0, 32'h0,        2, 0, 32'h12345678};
    vecs[3] = '{1'b1, 21'h000030, 4'hF, 32'hFFFFFFFF, 3, 1, 32'h12345678};
    vecs[4] = '{1'b1, 21'h000030, 4'h2, 32'h0000AB00, 3, 1, 32'h12345678};
    vecs[5] = '{1'b0, 21'h000030, 4'h0, 32'h0,        2, 0, 32'hFFFFABFF};
    vecs[6] = '{1'b1, 21'h000030, 4'h0, 32'h55555555, 3, 0, 32'hFFFFABFF};
    vecs[7] = '{1'b0, 21'h000030, 4'h0, 32'h0,        2, 0, 32'hFFFFABFF};

    sramMem[32'h10] = 32'hDEADBEEF;
    refMem[32'h10]  = 32'hDEADBEEF;

    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; be2 = '0; wdata2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ack/busy", {ack, busy}, 2'b00);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset strobes", {ceN, oeN, weN, sramDqOe, beN}, {8'hFC, 8'hFF});
    checkOutput("reset sram_addr", sramAddr, 40'h0);
    checkOutput("reset sram_dq_o", sramDqO, 32'h0);
    checkOutput("reset dutAlt", {ack2, busy2, ceN2, oeN2, weN2, sramDqOe2, rdata2},
                {2'b00, 8'hFC, 32'h0});
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vector table on default instance");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].d, lat, weLow, busyOk);
      checkOutput($sformatf("vec%0d ack latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("vec%0d we_n low cycles", i), weLow, vecs[i].expWeLow);
      checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d busy", i), busyOk, 1'b1);
      if (vecs[i].w) refWrite(int'(vecs[i].a), vecs[i].b, vecs[i].d);
    end
    lastRead = 32'hFFFFABFF;

    $display("[TB] RD_WAIT=0 WR_WAIT=3 instance");
    applyStimulusAlt(1'b0, 21'h100055, 4'h0, 32'h0, lat, weLow);
    checkOutput("alt read latency", lat, 1);
    checkOutput("alt read rdata", rdata2, {12'hC0D, 20'h00055});
    applyStimulusAlt(1'b1, 21'h000011, 4'hF, 32'hA1B2C3D4, lat, weLow);
    checkOutput("alt write latency", lat, 5);
    checkOutput("alt write we_n low cycles", weLow, 3);
    checkOutput("alt write rdata held", rdata2, {12'hC0D, 20'h00055});
    applyStimulusAlt(1'b1, 21'h100011, 4'h0, 32'hA1B2C3D4, lat, weLow);
    checkOutput("alt be0 write latency", lat, 5);
    checkOutput("alt be0 we_n low cycles", weLow, 0);
    applyStimulusAlt(1'b0, 21'h000022, 4'h0, 32'h0, lat, weLow);
    checkOutput("alt read2 latency", lat, 1);
    checkOutput("alt read2 rdata", rdata2, {12'hC0D, 20'h00022});

    $display("[TB] randomized accesses against memory reference");
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = {1'($urandom_range(0, 1)), 20'(32'h40 + $urandom_range(0, 7))};
      b = 4'($urandom_range(0, 15));
      d = $urandom;
      key = int'(a);
      expRd = w ? lastRead : refRead(key);
      applyStimulus(w, a, b, d, lat, weLow, busyOk);
      checkOutput($sformatf("rand%0d latency", i), lat, w ? 3 : 2);
      checkOutput($sformatf("rand%0d we_n low cycles", i), weLow,
                  (w && b != 4'h0) ? 1 : 0);
      checkOutput($sformatf("rand%0d rdata", i), rdata, expRd);
      checkOutput($sformatf("rand%0d busy", i), busyOk, 1'b1);
      if (w) refWrite(key, b, d);
      lastRead = expRd;
    end

    $display("[TB] req held high with alternating read/write");
    req = 1'b1; we = 1'b0; addr = 21'h000050; be = 4'h0; wdata = '0;
    starts = 0; acks = 0; prevAck = 1'b0; prevBusy = 1'b0;
    gapOk = 1'b1; typeOk = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (prevAck && (busy !== 1'b0 || ceN !== 2'b11)) gapOk = 1'b0;
      if (busy === 1'b1 && !prevBusy) begin
        starts++;
        ok = we ? (sramDqOe[0] === 1'b1 && oeN[0] === 1'b1)
                : (oeN[0] === 1'b0 && sramDqOe[0] === 1'b0);
        if (!ok) typeOk = 1'b0;
      end
      prevBusy = busy;
      prevAck  = ack;
      if (ack === 1'b1) begin
        acks++;
        we = ~we;
      end
    end
    req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
      if (busy === 1'b1 && !prevBusy) starts++;
      prevBusy = busy;
    end
    checkOutput("held req idle gap", gapOk, 1'b1);
    checkOutput("held req access type", typeOk, 1'b1);
    checkOutput("held req starts", starts, 10);
    checkOutput("held req acks", acks, 10);

    $display("[TB] reset during write pulse, req held across release");
    req = 1'b1; we = 1'b1; addr = 21'h000060; be = 4'hF; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre-reset we_n", weN, 2'b10);
    rst = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort strobes", {ceN, oeN, weN, sramDqOe, beN}, {8'hFC, 8'hFF});
    checkOutput("abort ack/busy", {ack, busy}, 2'b00);
    checkOutput("abort rdata", rdata, 32'h0);
    checkOutput("abort sram_addr/dq_o", {sramAddr, sramDqO}, 72'h0);
    // The we_n pulse reached the SRAM before the abort, so the word is
    // taken as written.
    refWrite(32'h60, 4'hF, 32'hCAFEF00D);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset accept busy", busy, 1'b1);
    checkOutput("post-reset accept ce_n", ceN, 2'b10);
    @(posedge clk); #1;
    checkOutput("post-reset ack early", ack, 1'b0);
    @(posedge clk); #1;
    checkOutput("post-reset ack", ack, 1'b1);
    checkOutput("post-reset rdata", rdata, refRead(32'h60));
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
